fifo2cmd: RTL and testbench

Parametrised command-frame parser between the command FIFO read side and the console register bank, running in the `sys_clk` domain. On an `fs` start it pulls one framed command from the FIFO: two header bytes, `NREG` payload bytes and an 8-bit checksum. Payload is committed atomically to a flat register vector only when the whole frame is valid. It generalises the fixed nine-register parser with a configurable register count, empty-aware reads, checksum checking, a stall timeout and coded errors.

---
 rtl/fifo2cmd_pkg.sv | 19 +
 rtl/fifo2cmd_if.sv | 23 ++
 rtl/fifo2cmd.sv | 167 ++++++++++++++++
 tb/tb_fifo2cmd.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo2cmd_pkg.sv
// Shared types and constants for the command-frame parser.
package fifo2cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_HEAD = 2'd1;
    localparam logic [1:0] ERR_SUM  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] HEAD0_DEF = 8'h55;
    localparam logic [7:0] HEAD1_DEF = 8'hAA;

endpackage

// File: rtl/fifo2cmd_if.sv
// Console/FIFO side signals of the command-frame parser.
interface fifo2cmd_if #(
    parameter int unsigned NREG = 9
) ();
    logic                fs;
    logic                fd;
    logic                fifo_rxen;
    logic [7:0]          fifo_rxd;
    logic                fifo_empty;
    logic [NREG*8-1:0]   cmd_regs;
    logic                cmd_vld;
    logic [1:0]          err;

    modport slave (
        input  fs, fifo_rxd, fifo_empty,
        output fd, fifo_rxen, cmd_regs, cmd_vld, err
    );

    modport master (
        output fs, fifo_rxd, fifo_empty,
        input  fd, fifo_rxen, cmd_regs, cmd_vld, err
    );
endinterface

// File: rtl/fifo2cmd.sv
// Pulls one framed command (header, NREG payload bytes, checksum) from the
// command FIFO and commits the payload atomically to the register vector.
module fifo2cmd
    import fifo2cmd_pkg::*;
#(
    parameter int unsigned NREG    = 9,
    parameter logic [7:0]  HEAD0   = HEAD0_DEF,
    parameter logic [7:0]  HEAD1   = HEAD1_DEF,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    fifo2cmd_if.slave    bus
);

    localparam int unsigned NBYTE   = NREG + 3;
    localparam int unsigned IDX_W   = $clog2(NREG + 4);
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0]   NBYTE_C   = IDX_W'(NBYTE);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NBYTE - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    iss_q, iss_d;
    logic [IDX_W-1:0]    rcv_q, rcv_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                vld_q;
    logic [7:0]          sum_q, sum_d;
    logic [7:0]          csum_q, csum_d;
    logic [NREG*8-1:0]   shadow_q, shadow_d;
    logic [NREG*8-1:0]   regs_q, regs_d;
    logic                cmd_vld_q, cmd_vld_d;
    logic                fd_q, fd_d;
    logic [1:0]          err_q, err_d;

    logic                more;
    logic                rxen;
    logic                stalled;
    logic                timeout;
    logic                head_bad;

    assign more    = (iss_q < NBYTE_C);
    assign rxen    = (state_q == ST_READ) && !bus.fifo_empty && more;
    assign stalled = (state_q == ST_READ) && bus.fifo_empty && more;
    assign timeout = stalled && (stall_q == STALL_MAX);

    assign head_bad = ((rcv_q == IDX_W'(0)) && (bus.fifo_rxd != HEAD0)) ||
                      ((rcv_q == IDX_W'(1)) && (bus.fifo_rxd != HEAD1));

    assign bus.fifo_rxen = rxen;
    assign bus.fd        = fd_q;
    assign bus.cmd_regs  = regs_q;
    assign bus.cmd_vld   = cmd_vld_q;
    assign bus.err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            iss_q     <= '0;
            rcv_q     <= '0;
            stall_q   <= '0;
            vld_q     <= 1'b0;
            sum_q     <= '0;
            csum_q    <= '0;
            shadow_q  <= '0;
            regs_q    <= '0;
            cmd_vld_q <= 1'b0;
            fd_q      <= 1'b0;
            err_q     <= ERR_OK;
        end else begin
            state_q   <= state_d;
            iss_q     <= iss_d;
            rcv_q     <= rcv_d;
            stall_q   <= stall_d;
            vld_q     <= rxen;
            sum_q     <= sum_d;
            csum_q    <= csum_d;
            shadow_q  <= shadow_d;
            regs_q    <= regs_d;
            cmd_vld_q <= cmd_vld_d;
            fd_q      <= fd_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        iss_d     = iss_q;
        rcv_d     = rcv_q;
        stall_d   = stall_q;
        sum_d     = sum_q;
        csum_d    = csum_q;
        shadow_d  = shadow_q;
        regs_d    = regs_q;
        cmd_vld_d = 1'b0;
        err_d     = err_q;
        fd_d      = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (bus.fs) begin
                    state_d = ST_READ;
                    iss_d   = '0;
                    rcv_d   = '0;
                    sum_d   = '0;
                    stall_d = '0;
                end
            end

            ST_READ: begin
                if (rxen) begin
                    iss_d = iss_q + IDX_W'(1);
                end
                if (!bus.fifo_empty) begin
                    stall_d = '0;
                end else if (stalled) begin
                    stall_d = stall_q + STALL_W'(1);
                end

                // A byte landing in the timeout cycle is dropped with the frame.
                if (timeout) begin
                    err_d   = ERR_TMO;
                    state_d = ST_DONE;
                end else if (vld_q) begin
                    rcv_d = rcv_q + IDX_W'(1);
                    if (head_bad) begin
                        err_d   = ERR_HEAD;
                        state_d = ST_DONE;
                    end else if (rcv_q == LAST_IDX) begin
                        csum_d  = bus.fifo_rxd;
                        state_d = ST_CHECK;
                    end else if (rcv_q >= IDX_W'(2)) begin
                        sum_d = sum_q + bus.fifo_rxd;
                        for (int unsigned k = 0; k < NREG; k++) begin
                            if (rcv_q == IDX_W'(k + 2)) begin
                                shadow_d[8*k +: 8] = bus.fifo_rxd;
                            end
                        end
                    end
                end
            end

            ST_CHECK: begin
                if (sum_q == csum_q) begin
                    regs_d    = shadow_q;
                    cmd_vld_d = 1'b1;
                    err_d     = ERR_OK;
                end else begin
                    err_d     = ERR_SUM;
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (!bus.fs) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo2cmd.sv
// Randomised self-checking bench for fifo2cmd with a frame-level reference model.
module tb_fifo2cmd;

    localparam int N   = 9;
    localparam int TMO = 16;
    localparam int NB  = N + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo2cmd_if #(.NREG(N)) bus ();

    fifo2cmd #(
        .NREG    (N),
        .HEAD0   (8'h55),
        .HEAD1   (8'hAA),
        .TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // FIFO stand-in
    logic [7:0] fq[$];
    logic [7:0] pend;
    bit         have_pend;
    int         hold, bub;
    bit         rand_bub;
    int         nreads, vld_cnt;
    bit         fs_drive, rst_drive;

    // Reference model: phase 0 idle, 1 collecting, 2 judging, 3 finished
    int         ph, iss, stall;
    logic [7:0] rx[$];
    bit         infl;
    logic       exp_fd, exp_vld;
    logic [1:0] exp_err;
    logic [71:0] exp_regs;

    task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic model_reset();
        ph = 0; iss = 0; stall = 0; rx.delete(); infl = 0;
        exp_fd = 0; exp_vld = 0; exp_err = 2'd0; exp_regs = '0;
    endtask

    function automatic bit exp_rxen(input bit empty);
        return (ph == 1) && !empty && (iss < NB);
    endfunction

    task automatic model_step(input bit fs, input bit empty, input logic [7:0] d, input bit rd);
        bit nfd;
        int idx;
        int s;
        if (rst_drive) begin
            model_reset();
            return;
        end
        nfd = (ph == 3);
        exp_vld = 0;
        case (ph)
            0: if (fs) begin
                ph = 1; iss = 0; stall = 0; rx.delete(); infl = 0;
            end
            1: begin
                if (empty && iss < NB) stall++;
                else if (!empty) stall = 0;
                if (stall == TMO) begin
                    exp_err = 2'd3; ph = 3;
                end else if (infl) begin
                    rx.push_back(d);
                    idx = rx.size() - 1;
                    if ((idx == 0 && d != 8'h55) || (idx == 1 && d != 8'hAA)) begin
                        exp_err = 2'd1; ph = 3;
                    end else if (idx == NB - 1) begin
                        ph = 2;
                    end
                end
                iss = iss + (rd ? 1 : 0);
                infl = rd;
            end
            2: begin
                s = 0;
                for (int k = 2; k < NB - 1; k++) s += int'(rx[k]);
                if ((s % 256) == int'(rx[NB-1])) begin
                    for (int k = 0; k < N; k++) exp_regs[8*k +: 8] = rx[k+2];
                    exp_vld = 1; exp_err = 2'd0;
                end else begin
                    exp_err = 2'd2;
                end
                ph = 3;
            end
            3: if (!fs) ph = 0;
            default: ph = 0;
        endcase
        exp_fd = nfd;
    endtask

    task automatic tick();
        bit erx;
        @(negedge clk);
        chk("fd", bus.fd, exp_fd);
        chk("cmd_vld", bus.cmd_vld, exp_vld);
        chk("err", bus.err, exp_err);
        chk("cmd_regs", bus.cmd_regs, exp_regs);
        if (bus.cmd_vld) vld_cnt++;
        rst = rst_drive;
        bus.fs = fs_drive;
        bus.fifo_rxd = have_pend ? pend : 8'($urandom);
        have_pend = 0;
        bus.fifo_empty = (fq.size() == 0) || (hold > 0);
        if (hold > 0) hold--;
        #1;
        erx = exp_rxen(bus.fifo_empty);
        chk("fifo_rxen", bus.fifo_rxen, erx);
        if (bus.fifo_rxen) begin
            nreads++;
            pend = (fq.size() > 0) ? fq.pop_front() : 8'h00;
            have_pend = 1;
            hold = rand_bub ? int'($urandom_range(0, 3)) : bub;
        end
        model_step(fs_drive, bus.fifo_empty, bus.fifo_rxd, erx);
    endtask

    // flaw: 0 none, 1 bad first header, 2 second header AB, 3 checksum+1
    task automatic load_frame(input logic [7:0] base, input bit rnd, input int flaw, input int keep);
        logic [7:0] b[$];
        logic [7:0] s, p;
        s = 8'h00;
        b.push_back(flaw == 1 ? (8'h55 ^ 8'($urandom_range(1, 255))) : 8'h55);
        b.push_back(flaw == 2 ? 8'hAB : 8'hAA);
        for (int k = 0; k < N; k++) begin
            p = rnd ? 8'($urandom) : base + 8'(k);
            s = s + p;
            b.push_back(p);
        end
        b.push_back(flaw == 3 ? s + 8'h01 : s);
        for (int k = 0; k < keep; k++) fq.push_back(b[k]);
    endtask

    task automatic run_frame(input int fs_len, output int lat);
        bit seen;
        int t;
        nreads = 0; vld_cnt = 0; lat = -1; seen = 0;
        for (t = 0; t < 600; t++) begin
            fs_drive = (t < fs_len);
            tick();
            if (!seen && bus.fd) begin
                seen = 1;
                lat = t - 1;
            end
            if (seen && !bus.fd && t >= fs_len) break;
        end
        chk("frame_done", seen, 1);
        chk("fd_release", bus.fd, 0);
        fs_drive = 0;
        tick();
        tick();
    endtask

    initial begin
        int lat;
        int r, flaw, keep;
        rst = 1'b1; rst_drive = 1; fs_drive = 0;
        have_pend = 0; hold = 0; bub = 0; rand_bub = 0;
        nreads = 0; vld_cnt = 0; pend = 8'h00;
        bus.fs = 1'b0; bus.fifo_empty = 1'b1; bus.fifo_rxd = 8'h00;
        model_reset();

        repeat (3) tick();
        chk("rst_fd", bus.fd, 0);
        chk("rst_rxen", bus.fifo_rxen, 0);
        chk("rst_regs", bus.cmd_regs, 0);
        chk("rst_vld", bus.cmd_vld, 0);
        chk("rst_err", bus.err, 0);
        rst_drive = 0;
        repeat (2) tick();

        // good frame
        load_frame(8'h01, 0, 0, NB);
        run_frame(1, lat);
        chk("good_lat", lat, 15);
        chk("good_regs", bus.cmd_regs, 72'h090807060504030201);
        chk("good_err", bus.err, 0);
        chk("good_reads", nreads, 12);
        chk("good_vld_cnt", vld_cnt, 1);

        // bad second header byte
        load_frame(8'h01, 0, 2, NB);
        run_frame(1, lat);
        chk("hdr_err", bus.err, 1);
        chk("hdr_regs", bus.cmd_regs, 72'h090807060504030201);
        chk("hdr_reads", nreads, 3);
        fq.delete();

        // bad checksum
        load_frame(8'h01, 0, 3, NB);
        run_frame(1, lat);
        chk("sum_err", bus.err, 2);
        chk("sum_vld_cnt", vld_cnt, 0);
        chk("sum_regs", bus.cmd_regs, 72'h090807060504030201);

        // 5-cycle empty bubble after every byte
        bub = 5;
        load_frame(8'h11, 0, 0, NB);
        run_frame(1, lat);
        chk("bub_lat", lat, 70);
        chk("bub_regs", bus.cmd_regs, 72'h191817161514131211);
        chk("bub_err", bus.err, 0);
        bub = 0;

        // starve after four bytes
        load_frame(8'h21, 0, 0, 4);
        run_frame(1, lat);
        chk("tmo_err", bus.err, 3);
        chk("tmo_reads", nreads, 4);
        chk("tmo_regs", bus.cmd_regs, 72'h191817161514131211);

        // asynchronous reset in the middle of the payload
        load_frame(8'h31, 0, 0, NB);
        nreads = 0;
        fs_drive = 1;
        tick();
        fs_drive = 0;
        for (int i = 0; i < 50 && nreads < 7; i++) tick();
        chk("rst_mid_reached", nreads >= 7, 1);
        #2;
        rst = 1'b1; rst_drive = 1;
        #1;
        chk("arst_fd", bus.fd, 0);
        chk("arst_rxen", bus.fifo_rxen, 0);
        chk("arst_regs", bus.cmd_regs, 0);
        chk("arst_vld", bus.cmd_vld, 0);
        chk("arst_err", bus.err, 0);
        model_reset();
        fq.delete(); have_pend = 0; hold = 0;
        tick(); tick();
        rst_drive = 0;
        tick(); tick();
        load_frame(8'hA0, 0, 0, NB);
        run_frame(1, lat);
        chk("post_rst_regs", bus.cmd_regs, 72'hA8A7A6A5A4A3A2A1A0);
        chk("post_rst_err", bus.err, 0);
        chk("post_rst_lat", lat, 15);

        // fs held through done; second frame waits in the FIFO
        load_frame(8'h41, 0, 0, NB);
        load_frame(8'h51, 0, 0, NB);
        nreads = 0;
        fs_drive = 1;
        for (int i = 0; i < 100 && !bus.fd; i++) tick();
        chk("hs_fd_rise", bus.fd, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hs_fd_hold", bus.fd, 1);
        end
        chk("hs_reads", nreads, 12);
        chk("hs_regs", bus.cmd_regs, 72'h494847464544434241);
        fs_drive = 0;
        tick(); tick(); tick();
        chk("hs_fd_drop", bus.fd, 0);
        tick();
        run_frame(1, lat);
        chk("hs_second_lat", lat, 15);
        chk("hs_second_regs", bus.cmd_regs, 72'h595857565554535251);

        // randomised frames, bubbles and start lengths
        rand_bub = 1;
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 9);
            flaw = (r < 6) ? 0 : ((r == 9) ? 0 : r - 5);
            keep = (r == 9) ? int'($urandom_range(0, NB - 1)) : NB;
            load_frame(8'h00, 1, flaw, keep);
            run_frame(int'($urandom_range(1, 25)), lat);
            fq.delete();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
